// File: rtl/regfile_mult_sequencer.sv
// Command sequencer for the register-file/multiplier datapath: issues WRITE/MUL
// commands, tracks products through the multiplier and returns them in order.
module regfile_mult_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int MUL_LATENCY = 3,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              w_en_n,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] result,
  output logic              idle
);

  localparam int PIPE_W = MUL_LATENCY + 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W  = $clog2(PIPE_W + RSP_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic              w_en_n_q, w_en_n_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic [PIPE_W-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

  logic             cmd_acc, mul_acc, wr_acc, push, pop;
  logic [SUM_W-1:0] inflight;

  assign cmd_acc = cmd_valid && cmd_ready;
  assign mul_acc = cmd_acc && cmd_op;
  assign wr_acc  = cmd_acc && !cmd_op;
  assign push    = pipe_q[MUL_LATENCY];
  assign pop     = rsp_valid && rsp_ready;

  // Credits: every product in the pipe already owns a FIFO slot, so the FIFO
  // can never overflow even though the consumer may stall indefinitely.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_W; i++) begin
      inflight = inflight + SUM_W'(pipe_q[i]);
    end
  end

  assign cmd_ready = (inflight + SUM_W'(count_q)) < SUM_W'(RSP_DEPTH);

  always_comb begin
    w_en_n_d = !wr_acc;
    w_addr_d = wr_acc ? cmd_addr : w_addr_q;
    w_data_d = wr_acc ? cmd_data : w_data_q;
    a_addr_d = mul_acc ? cmd_addr : a_addr_q;
    b_data_d = mul_acc ? cmd_data : b_data_q;
    pipe_d   = (pipe_q << 1) | PIPE_W'(mul_acc);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_en_n_q <= 1'b1;
      w_addr_q <= '0;
      w_data_q <= '0;
      a_addr_q <= '0;
      b_data_q <= '0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      w_en_n_q <= w_en_n_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      a_addr_q <= a_addr_d;
      b_data_q <= b_data_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks its head to zero.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= result;
    end
  end

  assign w_en_n    = w_en_n_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign a_addr    = a_addr_q;
  assign b_data    = b_data_q;
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? fifo_q[rd_ptr_q] : '0;
  assign idle      = (pipe_q == '0) && (count_q == '0);

endmodule

// File: doc/regfile_mult_sequencer.md
Name: regfile_mult_sequencer

Overview:
- Command-side initiator for the register-file/multiplier datapath.
- Accepts WRITE and MUL commands over a valid/ready interface and drives the datapath's write port (w_en_n, w_addr, w_data) and arith port (a_addr, b_data).
- Tracks the fixed multiply latency, captures each product from the datapath's result and returns it in order on a valid/ready response interface.
- Uses credit-based flow control so no product is ever dropped.

Parameters:
- ADDR_W, 8, register-file address width
- DATA_W, 16, data, operand and product width
- MUL_LATENCY, 3, clock edges from a_addr/b_data stable to result updated (multiplier pipeline depth)
- RSP_DEPTH, 4, response FIFO entries; must be ≥1

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready at rising edge
- cmd_op  in  1  0=WRITE, 1=MUL
- cmd_addr  in  ADDR_W  register address
- cmd_data  in  DATA_W  WRITE: write data; MUL: b operand
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer takes product when valid&&ready
- rsp_data  out  DATA_W  product, low DATA_W bits
- w_en_n  out  1  active-low write enable to datapath
- w_addr  out  ADDR_W  datapath write address
- w_data  out  DATA_W  datapath write data
- a_addr  out  ADDR_W  datapath read address (operand a)
- b_data  out  DATA_W  datapath operand b
- result  in  DATA_W  datapath product
- idle  out  1  nothing in flight and response FIFO empty

Behaviour:
- Reset (async, reset_n=0):
  - w_en_n=1; w_addr, w_data, a_addr, b_data = 0.
  - In-flight pipe cleared; FIFO emptied; rsp_valid=0; rsp_data=0; idle=1.
  - cmd_ready=1 once reset deasserts.
- All datapath outputs are registered. A command accepted at edge E drives its outputs during the cycle after E.
- WRITE accepted at E:
  - At E: w_en_n<=0, w_addr<=cmd_addr, w_data<=cmd_data.
  - The write therefore happens at datapath edge E+1.
  - No response is generated.
- When no WRITE is accepted at an edge, w_en_n<=1. w_addr and w_data hold their values.
- MUL accepted at E:
  - At E: a_addr<=cmd_addr, b_data<=cmd_data, pipe[0]<=1.
  - a_addr/b_data hold until the next MUL is accepted.
- Pipe: a valid shift register of MUL_LATENCY+1 bits, shifting every cycle; pipe[0]<=0 when no MUL is accepted.
  - When pipe[MUL_LATENCY]=1 at an edge, result is pushed into the FIFO at that edge.
  - Accept to rsp_valid = MUL_LATENCY+1 cycles (4 at defaults).
- Throughput: one command per cycle, any mix, back-to-back. WRITE at E followed by MUL to the same address at E+1 returns the new data: the register file write lands at E+1 and the read is asynchronous.
- Credits:
  - inflight = popcount(pipe); count = FIFO occupancy.
  - cmd_ready = (inflight + count) < RSP_DEPTH.
  - cmd_ready is a function of state only, independent of cmd_valid and cmd_op. WRITEs also wait for a credit, by design.
- FIFO:
  - Depth RSP_DEPTH, in order.
  - rsp_data = head entry; rsp_valid = count≠0.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by the credit rule; the bench asserts it.
- Arithmetic: no saturation. rsp_data is whatever result presents, i.e. the low DATA_W bits of a*b.
- idle = (pipe==0) && (count==0).
- Reset mid-operation:
  - In-flight products and buffered responses are discarded.
  - A WRITE already driven may or may not have completed in the datapath, since the datapath shares the same reset.

Test Plan:
- WRITE addr 0x05 data 0x1234, then MUL addr 0x05 b 0x0003 -> one response 0x369C, rsp_valid rising exactly 4 cycles after MUL accept.
- WRITE addr 0x10=0x0100 then next cycle MUL addr 0x10 b 0x0100 -> 0x0000 (truncated overflow). Second MUL addr 0x10 b 0x00FF -> 0xFF00.
- Back-to-back MULs over addrs 1..4 (data 2,3,4,5), b=0x0010, rsp_ready=1 -> responses 0x0020, 0x0030, 0x0040, 0x0050 on consecutive cycles; cmd_ready stays 1.
- rsp_ready=0, issue 6 MULs -> exactly 4 accepted, then cmd_ready=0. Toggle rsp_ready=1 for one cycle -> one pop, one credit freed, next MUL accepted. No loss, order preserved.
- Simultaneous FIFO push and pop with count=2 -> count stays 2, data order correct.
- Assert reset_n=0 with 3 MULs in flight and 1 buffered -> rsp_valid=0, idle=1, w_en_n=1 immediately (async). After release, no stale response appears over the next 10 cycles.
